// File: rtl/asic_latch_fifo_ctrl.sv
// FIFO controller for a single-read-port latch RAM.
// Presents valid/ready enqueue and dequeue streams and owns the write, commit and read pointers.
// An entry becomes visible to the consumer only once the RAM's delayed latch write has landed.
module asic_latch_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  // Enqueue stream
  input  logic                  i_enq_valid,
  output logic                  o_enq_ready,
  input  logic [DATA_WIDTH-1:0] i_enq_data,
  // Dequeue stream
  output logic                  o_deq_valid,
  input  logic                  i_deq_ready,
  output logic [DATA_WIDTH-1:0] o_deq_data,
  // Occupancy, including entries not yet committed
  output logic [ADDR_WIDTH:0]   o_count,
  // RAM write port
  output logic                  o_ram_write_enable,
  output logic [ADDR_WIDTH-1:0] o_ram_write_addr,
  output logic [DATA_WIDTH-1:0] o_ram_write_data,
  // RAM read port
  output logic [ADDR_WIDTH-1:0] o_ram_read_addr,
  input  logic [DATA_WIDTH-1:0] i_ram_read_data
);

  localparam int unsigned PtrW  = ADDR_WIDTH + 1;
  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [PtrW-1:0] FullCount = PtrW'(Depth);
  localparam logic [PtrW-1:0] PtrOne    = PtrW'(1);

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_cm_ptr;
  logic [PtrW-1:0] r_rd_ptr;

  logic [PtrW-1:0] w_count;
  logic            w_full;
  logic            w_enq_ready;
  logic            w_deq_valid;
  logic            w_push;
  logic            w_pop;

  // Occupancy, handshakes and RAM port drive.
  always_comb begin
    // Pointer width is exactly log2(2*DEPTH), so natural wrap gives the modular difference.
    w_count     = r_wr_ptr - r_rd_ptr;
    w_full      = (w_count == FullCount);
    // Deliberately independent of i_deq_ready: a full FIFO never accepts on the pop cycle.
    w_enq_ready = !w_full && !i_rst;
    // Only committed entries are visible, which hides the RAM's write landing delay.
    w_deq_valid = (r_cm_ptr != r_rd_ptr);
    // Flush wins over both handshakes; a coincident push never reaches the RAM.
    w_push      = i_enq_valid && w_enq_ready && !i_flush;
    w_pop       = w_deq_valid && i_deq_ready && !i_flush;

    o_enq_ready        = w_enq_ready;
    o_deq_valid        = w_deq_valid;
    o_count            = w_count;
    o_ram_write_enable = w_push;
    o_ram_write_addr   = r_wr_ptr[ADDR_WIDTH-1:0];
    o_ram_write_data   = i_enq_data;
    o_ram_read_addr    = r_rd_ptr[ADDR_WIDTH-1:0];
    o_deq_data         = i_ram_read_data;
  end

  // Pointer state: write and read advance on handshakes, commit trails write by one cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_cm_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      // Any write still landing in the RAM becomes unreachable once the pointers clear.
      r_wr_ptr <= '0;
      r_cm_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrOne;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrOne;
      end
      // Entry pushed in cycle N: wr_ptr moves at end of N, cm_ptr follows at end of N+1.
      r_cm_ptr <= r_wr_ptr;
    end
  end

endmodule

// File: tb/tb_asic_latch_fifo_ctrl.sv
// Bench for asic_latch_fifo_ctrl with a timing model of the latch RAM.
module tb_asic_latch_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       enq_valid;
  logic       enq_ready;
  logic [7:0] enq_data;
  logic       deq_valid;
  logic       deq_ready;
  logic [7:0] deq_data;
  logic [2:0] count;
  logic       ram_we;
  logic [1:0] ram_wa;
  logic [7:0] ram_wd;
  logic [1:0] ram_ra;
  logic [7:0] ram_rd;

  always #5 clk = ~clk;

  asic_latch_fifo_ctrl #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(2)
  ) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_flush            (flush),
    .i_enq_valid        (enq_valid),
    .o_enq_ready        (enq_ready),
    .i_enq_data         (enq_data),
    .o_deq_valid        (deq_valid),
    .i_deq_ready        (deq_ready),
    .o_deq_data         (deq_data),
    .o_count            (count),
    .o_ram_write_enable (ram_we),
    .o_ram_write_addr   (ram_wa),
    .o_ram_write_data   (ram_wd),
    .o_ram_read_addr    (ram_ra),
    .i_ram_read_data    (ram_rd)
  );

  // Latch RAM model: write registered at the edge, latch lands mid next cycle, read is async.
  logic       ram_we_q;
  logic [1:0] ram_wa_q;
  logic [7:0] ram_wd_q;
  logic [7:0] mem [4];

  always @(posedge clk) begin
    ram_we_q <= ram_we;
    ram_wa_q <= ram_wa;
    ram_wd_q <= ram_wd;
  end

  always @(negedge clk) begin
    if (ram_we_q === 1'b1) mem[ram_wa_q] <= ram_wd_q;
  end

  assign ram_rd = mem[ram_ra];

  // Reference model: ordered list of entries, each with the cycle it becomes visible.
  typedef struct {
    logic [7:0] data;
    int         avail;
  } ent_t;

  ent_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic model_visible();
    return (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
  endfunction

  // Model update at the edge, from the bench's own stimulus only.
  always @(posedge clk) begin
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      logic do_pop;
      logic do_push;
      do_pop  = deq_ready && model_visible();
      do_push = enq_valid && (exp_q.size() < 4);
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back('{data: enq_data, avail: cyc + 2});
    end
    cyc++;
  end

  // Monitor: compares DUT outputs against the model mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check("count", 32'(count), 32'(exp_q.size()));
      check("enq_ready", 32'(enq_ready), 32'(exp_q.size() < 4));
      check("deq_valid", 32'(deq_valid), 32'(model_visible()));
      if (model_visible() && deq_ready && !flush) begin
        check("deq_data", 32'(deq_data), 32'(exp_q[0].data));
      end
    end
  end

  task automatic tick(input logic ev, input logic [7:0] d, input logic dr, input logic fl);
    enq_valid = ev;
    enq_data  = d;
    deq_ready = dr;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    enq_valid = 1'b0;
    enq_data  = '0;
    deq_ready = 1'b0;
    #2;
    check("rst_enq_ready", 32'(enq_ready), 32'd0);
    check("rst_deq_valid", 32'(deq_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: single push, no fall-through
    tick(1'b1, 8'hA5, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);

    // 2: fill to full, fifth offer refused
    for (int i = 1; i <= 5; i++) tick(1'b1, 8'(i), 1'b0, 1'b0);

    // 3: pop on full with push held, push lands next cycle, drain in order
    tick(1'b1, 8'h05, 1'b1, 1'b0);
    tick(1'b1, 8'h05, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) tick(1'b0, 8'h00, 1'b1, 1'b0);

    // 4: steady stream across pointer wrap
    for (int i = 0; i < 20; i++) tick(1'b1, 8'(8'h10 + i), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 8'h00, 1'b1, 1'b0);

    // 5: flush with a coincident push at count 3
    for (int i = 0; i < 3; i++) tick(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    tick(1'b1, 8'h63, 1'b0, 1'b1);
    tick(1'b1, 8'h77, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);

    // 6: asynchronous reset between edges
    for (int i = 0; i < 3; i++) tick(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    enq_valid = 1'b0;
    #3;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("async_rst_enq_ready", 32'(enq_ready), 32'd0);
    check("async_rst_deq_valid", 32'(deq_valid), 32'd0);
    check("async_rst_count", 32'(count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(1'b1, 8'h99, 1'b0, 1'b0);
    tick(1'b1, 8'h9A, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      tick(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0, ($urandom % 40) == 0);
    end
    for (int i = 0; i < 8; i++) tick(1'b0, 8'h00, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
